// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader: FSM encoding, frame constants
// and the per-core depth multiplier also used by the instruction-memory side.
package instr_loader_pkg;

  localparam int HDR_FLAG_BIT    = 7;
  localparam int DEF_INSTR_WIDTH = 32;
  localparam int INSTR_BYTES     = (DEF_INSTR_WIDTH + 7) / 8;

  typedef enum logic [2:0] {
    IDLE,
    S_ADDR,
    S_CNT,
    S_DATA,
    S_CSUM
  } state_t;

  function automatic int instr_bytes(input int width);
    return (width + 7) / 8;
  endfunction

  // Depth multiplier is the lowest set bit of (core + 2^log_cores).
  function automatic int depth_mult(input int core, input int log_cores);
    int v;
    v = core + (1 << log_cores);
    return v & (-v);
  endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Host byte channel plus the replicated per-core instruction-memory write port.
interface instr_loader_if #(
  parameter int CORES       = 8,
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 32
) ();

  logic [7:0]                   in_data;
  logic                         in_valid;
  logic                         in_ready;
  logic [CORES-1:0]             we;
  logic [CORES*PC_WIDTH-1:0]    waddr;
  logic [CORES*INSTR_WIDTH-1:0] wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, we, waddr, wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, we, waddr, wdata
  );

endinterface

// File: rtl/instr_loader_word_assembler.sv
// instr_word_assembler: MSB-first byte shift register with a byte counter;
// word_done pulses the cycle after the final byte of a word is shifted in.
module instr_word_assembler
  import instr_loader_pkg::*;
#(
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_in,
  output logic [INSTR_WIDTH-1:0] word,
  output logic                   last_byte,
  output logic                   word_done
);

  localparam int NBYTES = instr_bytes(INSTR_WIDTH);
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [NBYTES*8-1:0] shreg;
  logic [CW-1:0]       cnt;

  assign last_byte = (cnt == CW'(NBYTES - 1));
  assign word      = shreg[INSTR_WIDTH-1:0];

  // clear only restarts the byte count so a pending word stays visible on wdata
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg     <= '0;
      cnt       <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= byte_valid && last_byte;
      if (clear) begin
        cnt <= '0;
      end else if (byte_valid) begin
        shreg <= (shreg << 8) | (NBYTES*8)'(byte_in);
        cnt   <= last_byte ? '0 : cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/instr_loader.sv
// instr_loader: parses HDR/ADDR/CNT/data frames and drives per-core write strobes.
// Define INSTR_LOADER_CHECKSUM_EN to require a trailing zero-sum checksum byte.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int CORES       = 8,
  parameter int LOG_CORES   = 3,
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 32,
  parameter int INSTR_DEPTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  instr_loader_if.slave bus,
  input  logic          clr_err,
  output logic          busy,
  output logic          done,
  output logic          err
);

  state_t                 state, state_next;
  logic [7:0]             in_byte;
  logic                   accept, hdr_accept, stray_byte, data_byte, frame_end;
  logic [LOG_CORES-1:0]   core_q;
  logic                   core_bad_q, core_bad_in;
  logic [PC_WIDTH-1:0]    addr_q;
  logic [7:0]             left_q;
  logic [INSTR_WIDTH-1:0] word;
  logic                   last_byte, word_done;
  logic [31:0]            core_depth;
  logic                   addr_ok, wr_ok, range_err, csum_err, err_set;
  logic                   done_q, err_q;

  assign in_byte      = bus.in_data;
  assign bus.in_ready = !rst;
  assign accept       = bus.in_valid && bus.in_ready;

`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam state_t DATA_EXIT = S_CSUM;
  logic [7:0] sum_q, sum_total;

  assign sum_total = sum_q + in_byte;
  assign csum_err  = accept && (state == S_CSUM) && (sum_total != 8'h00);

  always_ff @(posedge clk) begin
    if (rst)             sum_q <= '0;
    else if (hdr_accept) sum_q <= in_byte;
    else if (accept)     sum_q <= sum_total;
  end
`else
  localparam state_t DATA_EXIT = IDLE;
  assign csum_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept && in_byte[HDR_FLAG_BIT]) state_next = S_ADDR;
      S_ADDR:  if (accept) state_next = S_CNT;
      S_CNT:   if (accept) state_next = S_DATA;
      S_DATA:  if (accept && last_byte && left_q == 8'd0) state_next = DATA_EXIT;
      S_CSUM:  if (accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    hdr_accept = accept && (state == IDLE) && in_byte[HDR_FLAG_BIT];
    stray_byte = accept && (state == IDLE) && !in_byte[HDR_FLAG_BIT];
    data_byte  = accept && (state == S_DATA);
    frame_end  = accept && (state != IDLE) && (state_next == IDLE);
  end

  instr_word_assembler #(
    .INSTR_WIDTH(INSTR_WIDTH)
  ) u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (hdr_accept),
    .byte_valid(data_byte),
    .byte_in   (in_byte),
    .word      (word),
    .last_byte (last_byte),
    .word_done (word_done)
  );

  // Range is judged against the address presented in the strobe cycle
  assign core_bad_in = (32'(in_byte[LOG_CORES-1:0]) >= 32'(CORES));
  assign core_depth  = 32'(INSTR_DEPTH) * 32'(depth_mult(int'(core_q), LOG_CORES));
  assign addr_ok     = (32'(addr_q) < core_depth);
  assign wr_ok       = word_done && !core_bad_q && addr_ok;
  assign range_err   = word_done && !core_bad_q && !addr_ok;
  assign err_set     = stray_byte || range_err || (hdr_accept && core_bad_in) || csum_err;

  assign bus.we    = wr_ok ? (CORES'(1) << core_q) : '0;
  assign bus.waddr = {CORES{addr_q}};
  assign bus.wdata = {CORES{word}};
  assign done      = done_q;
  assign err       = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      core_q     <= '0;
      core_bad_q <= 1'b0;
      addr_q     <= '0;
      left_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= frame_end;
      if (hdr_accept) begin
        core_q     <= in_byte[LOG_CORES-1:0];
        core_bad_q <= core_bad_in;
      end
      if (accept && state == S_ADDR) addr_q <= PC_WIDTH'(in_byte);
      else if (word_done)            addr_q <= addr_q + 1'b1;
      if (accept && state == S_CNT)   left_q <= in_byte;
      else if (data_byte && last_byte) left_q <= left_q - 8'd1;
      if (err_set)      err_q <= 1'b1;
      else if (clr_err) err_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Table-driven bench for instr_loader; each vector is one clock of stimulus and
// the outputs observed just after that edge. Honours INSTR_LOADER_CHECKSUM_EN.
module tb_instr_loader;

`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, clr_err, busy, done, err;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  instr_loader_if #(.CORES(8), .PC_WIDTH(8), .INSTR_WIDTH(32)) bus ();

  instr_loader #(
    .CORES(8), .LOG_CORES(3), .PC_WIDTH(8), .INSTR_WIDTH(32), .INSTR_DEPTH(32)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .clr_err(clr_err),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  typedef struct {
    bit          rst;
    bit          vld;
    logic [7:0]  din;
    bit          clr;
    logic [7:0]  we;
    logic [7:0]  addr;
    logic [31:0] data;
    bit          chk_bus;
    bit          done;
    bit          err;
    bit          busy;
    string       name;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] run_sum;
  bit         e_err;

  task automatic applyStimulus(input bit r, input bit v, input logic [7:0] d, input bit c);
    rst          = r;
    bus.in_valid = v;
    bus.in_data  = d;
    clr_err      = c;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic addVec(input bit r, input bit v, input logic [7:0] d, input bit c,
                        input logic [7:0] we, input logic [7:0] a, input logic [31:0] w,
                        input bit chk, input bit dn, input bit e, input bit b, input string n);
    vec_t x;
    x.rst = r; x.vld = v; x.din = d; x.clr = c;
    x.we = we; x.addr = a; x.data = w; x.chk_bus = chk;
    x.done = dn; x.err = e; x.busy = b; x.name = n;
    vecs.push_back(x);
    if (v && !r) run_sum = run_sum + d;
  endtask

  task automatic byteV(input logic [7:0] d, input string n);
    addVec(0, 1, d, 0, 8'h00, 8'h00, 32'h0, 0, 0, e_err, 1, n);
  endtask

  // Final byte of an instruction: the strobe is visible right after its edge
  task automatic wordEnd(input logic [7:0] d, input logic [7:0] we, input logic [7:0] a,
                         input logic [31:0] w, input bit last, input string n);
    addVec(0, 1, d, 0, we, a, w, (we != 8'h00), last && !CS, e_err, !(last && !CS), n);
  endtask

  task automatic csumV(input bit corrupt, input string n);
    logic [7:0] cs;
    cs = (8'h00 - run_sum) ^ {7'b0, corrupt};
    addVec(0, 1, cs, 0, 8'h00, 8'h00, 32'h0, 0, 1, e_err, 0, n);
  endtask

  task automatic idleV(input bit c, input string n);
    addVec(0, 0, 8'h00, c, 8'h00, 8'h00, 32'h0, 0, 0, e_err, 0, n);
  endtask

  task automatic buildTable();
    e_err = 0; run_sum = 0;
    addVec(1, 0, 8'h00, 0, 8'h00, 8'h00, 32'h0, 1, 0, 0, 0, "reset0");
    addVec(1, 0, 8'h00, 0, 8'h00, 8'h00, 32'h0, 1, 0, 0, 0, "reset1");

    run_sum = 0;
    byteV(8'h81, "A hdr"); byteV(8'h10, "A addr"); byteV(8'h01, "A cnt");
    byteV(8'h11, "A d0"); byteV(8'h22, "A d1"); byteV(8'h33, "A d2");
    wordEnd(8'h44, 8'h02, 8'h10, 32'h11223344, 0, "A w0");
    byteV(8'h55, "A d4"); byteV(8'h66, "A d5"); byteV(8'h77, "A d6");
    wordEnd(8'h88, 8'h02, 8'h11, 32'h55667788, 1, "A w1");
    if (CS) csumV(0, "A csum");
    idleV(0, "A idle");

    run_sum = 0;
    byteV(8'h81, "B hdr"); byteV(8'h1F, "B addr"); byteV(8'h01, "B cnt");
    byteV(8'hAA, "B d0"); byteV(8'hBB, "B d1"); byteV(8'hCC, "B d2");
    wordEnd(8'hDD, 8'h02, 8'h1F, 32'hAABBCCDD, 0, "B w0");
    byteV(8'h01, "B d4"); byteV(8'h02, "B d5"); byteV(8'h03, "B d6");
    wordEnd(8'h04, 8'h00, 8'h00, 32'h0, 1, "B w1 suppressed");
    e_err = 1;
    if (CS) csumV(0, "B csum");
    idleV(0, "B err sticky");
    e_err = 0;
    idleV(1, "B clr");

    run_sum = 0;
    byteV(8'h80, "C hdr"); byteV(8'hFF, "C addr"); byteV(8'h01, "C cnt");
    byteV(8'h01, "C d0"); byteV(8'h02, "C d1"); byteV(8'h03, "C d2");
    wordEnd(8'h04, 8'h01, 8'hFF, 32'h01020304, 0, "C w0");
    byteV(8'h05, "C d4"); byteV(8'h06, "C d5"); byteV(8'h07, "C d6");
    wordEnd(8'h08, 8'h01, 8'h00, 32'h05060708, 1, "C w1 wrap");
    if (CS) csumV(0, "C csum");
    idleV(0, "C idle");

    e_err = 1;
    addVec(0, 1, 8'h05, 0, 8'h00, 8'h00, 32'h0, 0, 0, 1, 0, "stray");
    idleV(0, "stray sticky");
    e_err = 0;
    idleV(1, "stray clr");
    e_err = 1;
    addVec(0, 1, 8'h07, 1, 8'h00, 8'h00, 32'h0, 0, 0, 1, 0, "stray with clr");
    e_err = 0;
    idleV(1, "stray clr2");

    run_sum = 0;
    byteV(8'h82, "R hdr"); byteV(8'h20, "R addr");
    addVec(1, 0, 8'h00, 0, 8'h00, 8'h00, 32'h0, 1, 0, 0, 0, "R midframe reset");
    run_sum = 0;
    byteV(8'h82, "D hdr"); byteV(8'h30, "D addr"); byteV(8'h00, "D cnt");
    byteV(8'hDE, "D d0"); byteV(8'hAD, "D d1"); byteV(8'hBE, "D d2");
    wordEnd(8'hEF, 8'h04, 8'h30, 32'hDEADBEEF, 1, "D w0");
    if (CS) csumV(0, "D csum");

    run_sum = 0;
    byteV(8'h83, "E hdr"); byteV(8'h05, "E addr"); byteV(8'h00, "E cnt");
    byteV(8'h0A, "E d0"); byteV(8'h0B, "E d1"); byteV(8'h0C, "E d2");
    wordEnd(8'h0D, 8'h08, 8'h05, 32'h0A0B0C0D, 1, "E w0");
    if (CS) csumV(0, "E csum");
    run_sum = 0;
    byteV(8'h84, "F hdr b2b"); byteV(8'h7F, "F addr"); byteV(8'h00, "F cnt");
    byteV(8'h12, "F d0"); byteV(8'h34, "F d1"); byteV(8'h56, "F d2");
    wordEnd(8'h78, 8'h10, 8'h7F, 32'h12345678, 1, "F w0");
    if (CS) csumV(0, "F csum");
    idleV(0, "F idle");

    if (CS) begin
      run_sum = 0;
      byteV(8'h85, "G hdr"); byteV(8'h00, "G addr"); byteV(8'h00, "G cnt");
      byteV(8'hC0, "G d0"); byteV(8'hFF, "G d1"); byteV(8'hEE, "G d2");
      wordEnd(8'h11, 8'h20, 8'h00, 32'hC0FFEE11, 1, "G w0");
      e_err = 1;
      csumV(1, "G bad csum");
      idleV(0, "G err sticky");
      e_err = 0;
      idleV(1, "G clr");
    end
  endtask

  initial begin
    logic [7:0]  b8;
    logic [31:0] exp_w;
    rst = 1'b1; clr_err = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
    buildTable();
    $display("[TB] running %0d vectors", vecs.size());

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].rst, vecs[k].vld, vecs[k].din, vecs[k].clr);
      checkOutput({vecs[k].name, " we"}, 256'(bus.we), 256'(vecs[k].we));
      checkOutput({vecs[k].name, " done"}, 256'(done), 256'(vecs[k].done));
      checkOutput({vecs[k].name, " err"}, 256'(err), 256'(vecs[k].err));
      checkOutput({vecs[k].name, " busy"}, 256'(busy), 256'(vecs[k].busy));
      checkOutput({vecs[k].name, " in_ready"}, 256'(bus.in_ready), 256'(!vecs[k].rst));
      if (vecs[k].chk_bus) begin
        checkOutput({vecs[k].name, " waddr"}, 256'(bus.waddr), 256'({8{vecs[k].addr}}));
        checkOutput({vecs[k].name, " wdata"}, 256'(bus.wdata), 256'({8{vecs[k].data}}));
      end
    end

    // Maximum-length frame: 256 instructions into core 0 from address 0
    run_sum = 8'h80 + 8'hFF;
    applyStimulus(0, 1, 8'h80, 0);
    applyStimulus(0, 1, 8'h00, 0);
    applyStimulus(0, 1, 8'hFF, 0);
    for (int i = 0; i < 256; i++) begin
      b8    = 8'(i);
      exp_w = {b8, ~b8, b8, 8'hA5};
      for (int j = 0; j < 4; j++) begin
        applyStimulus(0, 1, exp_w[31-8*j -: 8], 0);
        run_sum = run_sum + exp_w[31-8*j -: 8];
      end
      checkOutput("long write", {bus.we, bus.waddr[7:0], bus.wdata[31:0]}, {8'h01, b8, exp_w});
    end
    checkOutput("long done", 256'(done), 256'(!CS));
    if (CS) begin
      applyStimulus(0, 1, 8'h00 - run_sum, 0);
      checkOutput("long csum done", 256'(done), 256'(1));
    end
    applyStimulus(0, 0, 8'h00, 0);
    checkOutput("long err", 256'(err), 256'(0));
    checkOutput("long busy", 256'(busy), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
